// File: rtl/mux4_sel_sequencer_pkg.sv
// Shared types and constants for the 4:1 mux select sequencer.
package mux4_sel_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // Channel index as driven onto {s1,s0}.
   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux4_sel_sequencer_rr_pick4.sv
// Round-robin picker: first set req bit at last_ch+1, +2, +3, +4 (mod 4).
module rr_pick4
   import mux4_sel_sequencer_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] last_ch,
   output logic [1:0] gnt_ch,
   output logic       gnt_any
);

   logic [1:0] idx;

   // Walk from the farthest offset down so the nearest requester wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_ch  = CH_A;
      idx     = '0;
      for (int i = 4; i >= 1; i--) begin
         idx = last_ch + 2'(i);
         if (req[idx]) begin
            gnt_any = 1'b1;
            gnt_ch  = idx;
         end
      end
   end

endmodule

// File: rtl/mux4_sel_sequencer.sv
// Drives the 4:1 mux selects for a round-robin granted channel, waits the
// settle time, samples y and hands the sample downstream via valid/ready.
module mux4_sel_sequencer
   import mux4_sel_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   input  logic       y,
   output logic       s1,
   output logic       s0,
   output logic       sel_valid,
   output logic       smp_data,
   output logic [1:0] smp_ch,
   output logic       smp_valid,
   input  logic       smp_ready,
   output logic       busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       sel;
   logic [1:0]       last_ch;
   logic [1:0]       rr_base;
   logic [1:0]       gnt_ch;
   logic             gnt_any;
   logic             hs_done;
   logic             settle_done;
   logic             grant;

   // A completing handshake moves the pointer in the same edge, so the
   // back-to-back search must start from the channel just served.
   assign hs_done     = (state == HOLD) && smp_ready;
   assign rr_base     = hs_done ? smp_ch : last_ch;
   assign settle_done = (state == SETTLE) && (cnt == CNT_LAST);
   assign grant       = en && gnt_any && ((state == IDLE) || hs_done);
   assign {s1, s0}    = sel;

   rr_pick4 u_pick (
      .req     (req),
      .last_ch (rr_base),
      .gnt_ch  (gnt_ch),
      .gnt_any (gnt_any)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: SETTLE ignores en/req; HOLD exits only on acceptance.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = SETTLE;
         SETTLE:  if (settle_done) state_nxt = HOLD;
         HOLD:    if (hs_done) state_nxt = grant ? SETTLE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decode straight from the state.
   always_comb begin
      sel_valid = (state == SETTLE) || (state == HOLD);
      busy      = (state != IDLE);
      smp_valid = (state == HOLD);
   end

   // Datapath: selects latch on grant, counter runs in SETTLE, sample
   // captured on the last settle edge, pointer advances on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel      <= CH_A;
         cnt      <= '0;
         last_ch  <= CH_D;
         smp_data <= 1'b0;
         smp_ch   <= CH_A;
      end else begin
         if (grant) begin
            sel <= gnt_ch;
            cnt <= '0;
         end else if ((state == SETTLE) && !settle_done) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (settle_done) begin
            smp_data <= y;
            smp_ch   <= sel;
         end
         if (hs_done) last_ch <= smp_ch;
      end
   end

endmodule

// File: tb/tb_mux4_sel_sequencer.sv
// Directed bench for mux4_sel_sequencer (SETTLE_CYCLES=2).
module tb_mux4_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       y;
   logic       s1, s0, sel_valid, smp_data, smp_valid, busy;
   logic [1:0] smp_ch;
   logic       smp_ready = 1'b0;
   logic [3:0] mux_data = 4'b1101;   // {D,C,B,A}

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   typedef struct {
      logic [3:0] req;
      logic [3:0] data;
      logic [1:0] ch;
      logic       dat;
   } vec_t;

   vec_t vecs[7];

   // Behavioural 4:1 mux fed by the selects.
   assign y = mux_data[{s1, s0}];

   always #5 clk = ~clk;

   mux4_sel_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .y         (y),
      .s1        (s1),
      .s0        (s0),
      .sel_valid (sel_valid),
      .smp_data  (smp_data),
      .smp_ch    (smp_ch),
      .smp_valid (smp_valid),
      .smp_ready (smp_ready),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Waits at negedges for smp_valid, bounded; returns negedges elapsed.
   task automatic wait_valid(output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!smp_valid && c < 30);
      if (!smp_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_valid: smp_valid never rose, expected within 30 cycles");
      end
   endtask

   function automatic logic [7:0] all_outs();
      return {s1, s0, sel_valid, smp_data, smp_ch, smp_valid, busy};
   endfunction

   initial begin
      vecs[0] = '{4'b1111, 4'b1101, 2'd0, 1'b1};
      vecs[1] = '{4'b1111, 4'b1101, 2'd1, 1'b0};
      vecs[2] = '{4'b1111, 4'b1101, 2'd2, 1'b1};
      vecs[3] = '{4'b1111, 4'b1101, 2'd3, 1'b1};
      vecs[4] = '{4'b1111, 4'b1101, 2'd0, 1'b1};
      vecs[5] = '{4'b1001, 4'b0110, 2'd3, 1'b0};
      vecs[6] = '{4'b1001, 4'b0110, 2'd0, 1'b0};

      // Power-on reset
      #1 rst_n = 1'b0;
      #1 chk("reset_outs", 32'(all_outs()), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request on C
      mux_data  = 4'b1101;
      en        = 1'b1;
      req       = 4'b0100;
      smp_ready = 1'b1;
      @(negedge clk);
      chk("single_grant", 32'({s1, s0, sel_valid, smp_valid, busy}), 32'b10101);
      req = 4'b0000;
      @(negedge clk);
      chk("single_settle", 32'(smp_valid), 32'h0);
      @(negedge clk);
      chk("single_smp", 32'({smp_valid, smp_data, smp_ch}), 32'b1110);
      @(negedge clk);
      chk("single_idle", 32'({busy, sel_valid, smp_valid, s1, s0}), 32'b00010);

      // Fresh pointer for the round-robin table
      rst_n = 1'b0;
      #2 rst_n = 1'b1;

      // Round-robin and idle-channel skipping, back-to-back
      req      = vecs[0].req;
      mux_data = vecs[0].data;
      for (int i = 0; i < 7; i++) begin
         wait_valid(cyc);
         chk($sformatf("rr%0d_period", i), 32'(cyc), 32'd3);
         chk($sformatf("rr%0d_ch", i), 32'(smp_ch), 32'(vecs[i].ch));
         chk($sformatf("rr%0d_data", i), 32'(smp_data), 32'(vecs[i].dat));
         chk($sformatf("rr%0d_sel", i), 32'({s1, s0}), 32'(vecs[i].ch));
         if (i < 6) begin
            req      = vecs[i+1].req;
            mux_data = vecs[i+1].data;
         end else begin
            req = 4'b0000;
         end
      end
      @(negedge clk);
      chk("rr_end_idle", 32'({busy, sel_valid}), 32'h0);

      // Backpressure on B, y flips while held
      smp_ready = 1'b0;
      req       = 4'b0010;
      mux_data  = 4'b0010;
      wait_valid(cyc);
      chk("bp_latency", 32'(cyc), 32'd3);
      req      = 4'b0000;
      mux_data = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", k),
             32'({smp_valid, smp_data, smp_ch, s1, s0, sel_valid}), 32'b1101011);
      end
      smp_ready = 1'b1;
      req       = 4'b1000;
      mux_data  = 4'b1000;
      @(negedge clk);
      chk("bp_regrant", 32'({s1, s0, sel_valid, smp_valid}), 32'b1110);

      // en drops during SETTLE: sample still delivered, then idle
      en  = 1'b0;
      req = 4'b1111;
      wait_valid(cyc);
      chk("endrop_latency", 32'(cyc), 32'd2);
      chk("endrop_smp", 32'({smp_data, smp_ch}), 32'b111);
      @(negedge clk);
      chk("endrop_idle", 32'({busy, sel_valid, smp_valid}), 32'h0);
      @(negedge clk);
      chk("endrop_stay", 32'({busy, sel_valid, smp_valid}), 32'h0);

      // Reset in the middle of SETTLE
      en       = 1'b1;
      req      = 4'b0100;
      mux_data = 4'b1101;
      wait_valid(cyc);
      chk("rst_pre_ch", 32'(smp_ch), 32'd2);
      req = 4'b0010;
      @(negedge clk);
      chk("rst_pre_settle", 32'({s1, s0, busy}), 32'b011);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", 32'(all_outs()), 32'h0);
      req = 4'b1111;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_first_grant", 32'({s1, s0, sel_valid, busy}), 32'b0011);
      wait_valid(cyc);
      chk("rst_first_smp", 32'({smp_data, smp_ch}), 32'b100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
